// File: rtl/ads131a0x_gpio_in.sv
// ---------------------------------------------------------------------------
// ads131a0x_gpio_in
//
// Avalon-MM input PIO for the ADS131A0X subsystem. Samples the converter's
// status lines (DRDY, DONE), latches the selected edge into sticky capture
// bits, records captures lost to overrun and raises a maskable level
// interrupt towards the host CPU.
//
// Parameters:
//   WIDTH      number of input lines (1..32)
//   EDGE_TYPE  capture edge: 0 rising, 1 falling, 2 any (default falling,
//              because DRDY is active-low)
//
// Ports:
//   clk         system clock, the only clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 OVERRUN, 2 IRQMASK, 3 EDGECAP)
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous input lines from the converter
//   readdata    registered read data, fixed read latency of one clock
//   irq         level interrupt, active-high
// ---------------------------------------------------------------------------
module ads131a0x_gpio_in #(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_OVERRUN = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam logic [1:0] ARM_DONE = 2'd3;

  // Synchronizer and edge-history registers
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;

  // Arm counter, holds edge detection off for the first cycles after reset
  logic [1:0] arm_cnt;
  logic       armed;

  // Software-visible registers
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] overrun;
  logic [WIDTH-1:0] irqmask;

  // Combinational helpers
  logic             wr;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_edgecap;
  logic [WIDTH-1:0] clr_overrun;
  logic [WIDTH-1:0] overrun_set;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] overrun_next;
  logic [31:0]      read_mux;

  // Only the low WIDTH bits of writedata carry register content; the rest
  // is folded here so the unused bits are explicitly acknowledged.
  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata};

  // Two-flop synchronizer into the clock domain, plus one more stage that
  // holds the previous synchronized value for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= s2;
    end
  end

  // The synchronizer comes out of reset with zeros, so a line held high
  // through reset would look like a rising edge while the pipeline fills.
  // The counter saturates at 3 and detection stays off until then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= 2'd0;
    end else if (arm_cnt != ARM_DONE) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign armed = (arm_cnt == ARM_DONE);

  // Per-bit edge selection from the synchronized value and its predecessor.
  // Unsupported EDGE_TYPE values fall back to "any edge".
  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      0:       raw_edge = s2 & ~prev;
      1:       raw_edge = ~s2 & prev;
      default: raw_edge = s2 ^ prev;
    endcase
  end

  assign edge_det = armed ? raw_edge : '0;

  // Write-one-to-clear masks. A set arriving in the same cycle as a clear
  // wins, so the clear is applied first and the set OR-ed on top.
  assign wr          = chipselect & ~write_n;
  assign clr_edgecap = (wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
  assign clr_overrun = (wr && (address == ADDR_OVERRUN)) ? writedata[WIDTH-1:0] : '0;

  // An overrun means a new edge landed on a capture bit that software has
  // not yet acknowledged. If software is clearing that very bit in this
  // cycle the new edge simply replaces the old one, so nothing is lost.
  assign overrun_set  = edge_det & edgecap & ~clr_edgecap;
  assign edgecap_next = (edgecap & ~clr_edgecap) | edge_det;
  assign overrun_next = (overrun & ~clr_overrun) | overrun_set;

  // Sticky capture and overrun registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
      overrun <= '0;
    end else begin
      edgecap <= edgecap_next;
      overrun <= overrun_next;
    end
  end

  // Interrupt mask, plain read/write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr && (address == ADDR_IRQMASK)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux. Register contents are zero-extended to the 32-bit bus by
  // starting from zero and overlaying the low WIDTH bits, which also works
  // when WIDTH is 32.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:    read_mux[WIDTH-1:0] = s2;
      ADDR_OVERRUN: read_mux[WIDTH-1:0] = overrun;
      ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap;
      default:      read_mux = '0;
    endcase
  end

  // Read data is registered every cycle without a read strobe, giving a
  // fixed latency of one clock. Reads never disturb register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

  // Interrupt depends only on registers, so it has no combinational path
  // from any input and falls as soon as reset clears the registers.
  assign irq = |(edgecap & irqmask);

endmodule

// File: doc/ads131a0x_gpio_in.md
# ads131a0x_gpio_in

Avalon-MM input PIO for the ADS131A0X subsystem: it samples the converter's status lines (DRDY, DONE), latches selected edges into sticky capture bits, flags captures lost to overrun, and raises a maskable interrupt to the host CPU. It is the read-side counterpart of the existing 2-bit output PIO that drives the converter's control lines. Both sit on the same Avalon-MM bus and clock.

## Interface

Parameters:
- `WIDTH`, 2, number of input lines (1..32).
- `EDGE_TYPE`, 1, capture edge: 0 rising, 1 falling, 2 any. Default 1 because DRDY is active-low.

Ports (clock and reset first):
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous input lines from the converter.
- `readdata`  out  32  registered read data. Fixed read latency 1.
- `irq`  out  1  level interrupt, active-high.

## Operation

- Synchronizer:
  - `s1 <= in_port`, `s2 <= s1`, `prev <= s2`.
  - All three stages reset to 0.
- Edge detect, per bit, from `s2` and `prev`:
  - rising = `s2 & ~prev`
  - falling = `~s2 & prev`
  - any = `s2 ^ prev`
- Arm counter:
  - 2-bit counter, reset to 0, increments to 3 and saturates.
  - Edge detection is gated off until the counter reaches 3, so lines held high through reset produce no spurious edge.
- Register map (`wr` = `chipselect & ~write_n`):
  - 0 DATA (RO): `s2`, zero-extended. Writes ignored.
  - 1 OVERRUN (R/W1C): bit i sets when an edge is detected on bit i while capture bit i is already 1 and is not being cleared this cycle.
  - 2 IRQMASK (R/W): `writedata[WIDTH-1:0]`.
  - 3 EDGECAP (R/W1C): bit i sets on a detected edge. A write of 1 to bit i clears it.
- Set/clear priority:
  - On EDGECAP and OVERRUN, a set in the same cycle as a W1C clear wins; the bit stays 1.
  - When an EDGECAP bit is cleared and set in the same cycle, no overrun is recorded for that bit.
- `irq = |(EDGECAP & IRQMASK)`, driven from registers with no combinational input path.
- `readdata` is registered every cycle from the `address` mux, with no read strobe. Upper `32-WIDTH` bits are 0. Reads have no side effects.
- Reset values: `readdata` = 0, `irq` = 0, IRQMASK = 0, EDGECAP = 0, OVERRUN = 0, arm counter = 0.
- Reset asserted mid-operation clears all state immediately, including pending captures. `irq` drops asynchronously.

## Timing

- An `in_port` change that meets setup before edge k:
  - appears in `s2` after edge k+1;
  - sets the EDGECAP bit at edge k+2;
  - `irq` is high after edge k+2 if the bit is masked in;
  - is visible in a DATA read presented at edge k+2, with `readdata` valid after k+2.
- Register write at edge w: the new value is in the register after w. `irq` reflects an IRQMASK or EDGECAP write after w.
- Read with `address` held before edge r returns `readdata` valid after r. Latency is 1 clock.
- Pulses shorter than one clock may be missed. That is acceptable; DRDY pulses are multi-cycle.
- After `reset_n` deasserts, edges are detected from the 4th rising `clk` onward.

## Test plan

- Reset with `in_port`=2'b11, release, hold 10 cycles → EDGECAP=0, `irq`=0, DATA read=0x3.
- EDGE_TYPE=1, IRQMASK=0x1, drive bit0 1→0 → EDGECAP=0x1 and `irq`=1 exactly 2 clocks later. Write 0x1 to addr 3 → EDGECAP=0, `irq`=0 next cycle.
- Two falling edges on bit1 without clearing → EDGECAP=0x2, OVERRUN=0x2. Write 0x2 to addr 1 → OVERRUN=0.
- W1C of EDGECAP bit0 in the same cycle as a new edge on bit0 → EDGECAP stays 0x1, OVERRUN=0.
- IRQMASK=0 with an edge captured → `irq`=0. Then write IRQMASK=0x3 → `irq`=1 one clock later.
- Assert `reset_n` while EDGECAP=0x3 and `irq`=1 → `irq`, `readdata`, and all registers are 0 without a clock edge.
